// File: rtl/csr_regs_pkg.sv
// ---------------------------------------------------------------------------
// csr_regs_pkg
// Shared constants for the I2C-slave CSR block: register addresses, unlock
// key values, CTRL bit positions and the lock FSM state encoding.
// ---------------------------------------------------------------------------
package csr_regs_pkg;

  localparam logic [4:0] ADDR_ID         = 5'h00;
  localparam logic [4:0] ADDR_SCRATCH    = 5'h01;
  localparam logic [4:0] ADDR_CTRL       = 5'h02;
  localparam logic [4:0] ADDR_KEY        = 5'h03;
  localparam logic [4:0] ADDR_IRQ_STATUS = 5'h04;
  localparam logic [4:0] ADDR_IRQ_EN     = 5'h05;
  localparam logic [4:0] ADDR_CNT0       = 5'h08;
  localparam logic [4:0] ADDR_CNT1       = 5'h09;
  localparam logic [4:0] ADDR_CNT2       = 5'h0A;
  localparam logic [4:0] ADDR_CNT3       = 5'h0B;
  localparam logic [4:0] ADDR_PROT0      = 5'h10;
  localparam logic [4:0] ADDR_PROT1      = 5'h11;
  localparam logic [4:0] ADDR_PROT2      = 5'h12;
  localparam logic [4:0] ADDR_PROT3      = 5'h13;

  localparam logic [7:0] KEY1_VAL = 8'h55;
  localparam logic [7:0] KEY2_VAL = 8'hAA;

  localparam int CTRL_SNAP     = 0;
  localparam int CTRL_CLR      = 1;
  localparam int CTRL_PERR     = 6;
  localparam int CTRL_UNLOCKED = 7;

  typedef enum logic [1:0] {
    LOCK_LOCKED   = 2'd0,
    LOCK_KEY1     = 2'd1,
    LOCK_UNLOCKED = 2'd2
  } lock_state_t;

endpackage

// File: rtl/csr_regs_lock.sv
// ---------------------------------------------------------------------------
// csr_lock
// Two-key unlock sequence (KEY1_VAL then KEY2_VAL to the KEY register) that
// opens the protected config word, plus an optional relock timeout.
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   csr_we         any CSR write this cycle
//   key_we         CSR write addressed to KEY this cycle
//   key_data       write data (valid with key_we)
//   prot_we        CSR write addressed to any PROT byte this cycle
//   unlocked       PROT writes are accepted this cycle
//   reject_pulse   a PROT write this cycle is being dropped
//   state          current lock state (debug / status)
// ---------------------------------------------------------------------------
module csr_lock
  import csr_regs_pkg::*;
#(
  parameter logic [15:0] UNLOCK_TIMEOUT = 16'd50000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        csr_we,
  input  logic        key_we,
  input  logic [7:0]  key_data,
  input  logic        prot_we,
  output logic        unlocked,
  output logic        reject_pulse,
  output lock_state_t state
);

  localparam bit TIMEOUT_EN = (UNLOCK_TIMEOUT != 16'd0);

  lock_state_t state_n;
  logic [15:0] timer;
  logic [15:0] timer_n;
  logic        expire;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= LOCK_LOCKED;
      timer <= 16'd0;
    end else begin
      state <= state_n;
      timer <= timer_n;
    end
  end

  // The timer holds the number of UNLOCKED cycles left, so the cycle where it
  // reads 1 is the expiry cycle: the FSM is still UNLOCKED but a PROT write
  // there is already refused.
  always_comb begin
    state_n = state;
    timer_n = timer;
    expire  = 1'b0;
    case (state)
      LOCK_LOCKED: begin
        if (key_we && key_data == KEY1_VAL) state_n = LOCK_KEY1;
      end
      LOCK_KEY1: begin
        if (key_we && key_data == KEY2_VAL) begin
          state_n = LOCK_UNLOCKED;
          timer_n = UNLOCK_TIMEOUT;
        end else if (csr_we) begin
          state_n = LOCK_LOCKED;
        end
      end
      LOCK_UNLOCKED: begin
        if (key_we) begin
          state_n = LOCK_LOCKED;
          timer_n = 16'd0;
        end else if (TIMEOUT_EN) begin
          if (timer == 16'd1) begin
            expire  = 1'b1;
            state_n = LOCK_LOCKED;
            timer_n = 16'd0;
          end else begin
            timer_n = timer - 16'd1;
          end
        end
      end
      default: begin
        state_n = LOCK_LOCKED;
        timer_n = 16'd0;
      end
    endcase
  end

  assign unlocked     = (state == LOCK_UNLOCKED) && !expire;
  assign reject_pulse = prot_we && !unlocked;

endmodule

// File: rtl/csr_regs.sv
// ---------------------------------------------------------------------------
// csr_regs
// Control/status register file for the CSR side of the I2C slave: ID,
// scratch, event counter with snapshot, W1C interrupt status with enable and
// a key-locked 32-bit protected config word.
//
// Bus protocol: csr_we is a single-cycle strobe with csr_a/csr_do valid in the
// same cycle; there is no ready/stall, every strobe is consumed on that edge.
// csr_di is purely combinational from csr_a and shows written values from the
// cycle after the write edge.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   csr_a        register address (32-byte space)
//   csr_we       write strobe
//   csr_do       write data
//   csr_di       read data
//   cnt_tick     event counter increment enable
//   irq_src      level interrupt sources (rising edge sets status)
//   irq          registered |(status & enable)
//   prot_cfg     protected configuration word
// ---------------------------------------------------------------------------
module csr_regs
  import csr_regs_pkg::*;
#(
  parameter logic [7:0]  VERSION        = 8'h01,
  parameter logic [31:0] PROT_RESET     = 32'h0000_0000,
  parameter logic [15:0] UNLOCK_TIMEOUT = 16'd50000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  csr_a,
  input  logic        csr_we,
  input  logic [7:0]  csr_do,
  output logic [7:0]  csr_di,
  input  logic        cnt_tick,
  input  logic [7:0]  irq_src,
  output logic        irq,
  output logic [31:0] prot_cfg
);

  logic [7:0]  scratch;
  logic        perr;
  logic [7:0]  irq_status;
  logic [7:0]  irq_en;
  logic [7:0]  irq_src_q;
  logic [31:0] counter;
  logic [31:0] snapshot;

  logic        wr_scratch;
  logic        wr_ctrl;
  logic        wr_key;
  logic        wr_status;
  logic        wr_en;
  logic        wr_prot;
  logic        unlocked;
  logic        reject_pulse;
  lock_state_t lock_state;

  assign wr_scratch = csr_we && (csr_a == ADDR_SCRATCH);
  assign wr_ctrl    = csr_we && (csr_a == ADDR_CTRL);
  assign wr_key     = csr_we && (csr_a == ADDR_KEY);
  assign wr_status  = csr_we && (csr_a == ADDR_IRQ_STATUS);
  assign wr_en      = csr_we && (csr_a == ADDR_IRQ_EN);
  assign wr_prot    = csr_we && (csr_a[4:2] == ADDR_PROT0[4:2]);

  csr_lock #(
    .UNLOCK_TIMEOUT (UNLOCK_TIMEOUT)
  ) u_lock (
    .clk          (clk),
    .rst_n        (rst_n),
    .csr_we       (csr_we),
    .key_we       (wr_key),
    .key_data     (csr_do),
    .prot_we      (wr_prot),
    .unlocked     (unlocked),
    .reject_pulse (reject_pulse),
    .state        (lock_state)
  );

  // Plain RW registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scratch <= 8'h00;
      irq_en  <= 8'h00;
    end else begin
      if (wr_scratch) scratch <= csr_do;
      if (wr_en)      irq_en  <= csr_do;
    end
  end

  // PERR: a rejected PROT write wins over a same-cycle W1C.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perr <= 1'b0;
    end else if (reject_pulse) begin
      perr <= 1'b1;
    end else if (wr_ctrl && csr_do[CTRL_PERR]) begin
      perr <= 1'b0;
    end
  end

  // Event counter. SNAP samples the register value before this edge's
  // clear/increment, so SNAP+CLR together captures the pre-clear count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      counter  <= 32'd0;
      snapshot <= 32'd0;
    end else begin
      if (wr_ctrl && csr_do[CTRL_SNAP]) snapshot <= counter;
      if (wr_ctrl && csr_do[CTRL_CLR]) begin
        counter <= 32'd0;
      end else if (cnt_tick) begin
        counter <= counter + 32'd1;
      end
    end
  end

  // Interrupts: rising-edge set beats a same-cycle W1C clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_src_q  <= 8'h00;
      irq_status <= 8'h00;
      irq        <= 1'b0;
    end else begin
      irq_src_q  <= irq_src;
      irq_status <= (irq_status & ~(wr_status ? csr_do : 8'h00))
                  | (irq_src & ~irq_src_q);
      irq        <= |(irq_status & irq_en);
    end
  end

  // Protected config word, byte-writable only while unlocked.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prot_cfg <= PROT_RESET;
    end else if (wr_prot && unlocked) begin
      prot_cfg[{csr_a[1:0], 3'b000} +: 8] <= csr_do;
    end
  end

  // Read mux.
  always_comb begin
    csr_di = 8'h00;
    case (csr_a)
      ADDR_ID:         csr_di = VERSION;
      ADDR_SCRATCH:    csr_di = scratch;
      ADDR_CTRL: begin
        csr_di[CTRL_PERR]     = perr;
        csr_di[CTRL_UNLOCKED] = (lock_state == LOCK_UNLOCKED);
      end
      ADDR_IRQ_STATUS: csr_di = irq_status;
      ADDR_IRQ_EN:     csr_di = irq_en;
      ADDR_CNT0:       csr_di = snapshot[7:0];
      ADDR_CNT1:       csr_di = snapshot[15:8];
      ADDR_CNT2:       csr_di = snapshot[23:16];
      ADDR_CNT3:       csr_di = snapshot[31:24];
      ADDR_PROT0:      csr_di = prot_cfg[7:0];
      ADDR_PROT1:      csr_di = prot_cfg[15:8];
      ADDR_PROT2:      csr_di = prot_cfg[23:16];
      ADDR_PROT3:      csr_di = prot_cfg[31:24];
      default:         csr_di = 8'h00;
    endcase
  end

endmodule

// File: doc/csr_regs.md
Name: csr_regs

Overview:
- Control/status register file on the CSR side of the I2C slave; consumes its csr_a/csr_we/csr_do and returns csr_di.
- 32-byte address space. Provides ID, scratch, snapshot of a 32-bit event counter, W1C interrupt status with enable, and a key-locked 32-bit protected config word.
- All CSR writes are single-cycle pulses; reads are combinational from csr_a.

Parameters:
- VERSION, 8'h01, value returned at address 0x00
- PROT_RESET, 32'h0000_0000, reset value of prot_cfg
- UNLOCK_TIMEOUT, 16'd50000, clk cycles after unlock before automatic relock; 0 disables the timeout

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- csr_a  in  5  register address
- csr_we  in  1  write strobe, one cycle
- csr_do  in  8  write data, valid with csr_we
- csr_di  out  8  read data, combinational from csr_a
- cnt_tick  in  1  counter increment enable, synchronous to clk
- irq_src  in  8  interrupt sources, synchronous to clk, level
- irq  out  1  registered interrupt output
- prot_cfg  out  32  protected configuration word

Behaviour:
- Reset (rst_n low, async):
  - all registers 0, except prot_cfg = PROT_RESET
  - lock FSM = LOCKED; irq = 0; counter = 0; snapshot = 0
  - irq_src edge-detect history = 0
  - Reset asserted mid-access discards the access.
- Address map:
  - 0x00 ID: read-only, VERSION.
  - 0x01 SCRATCH: RW.
  - 0x02 CTRL:
    - bit0 SNAP: write 1 copies the live counter into snapshot on the same clk edge; reads 0.
    - bit1 CLR: write 1 zeroes the counter; reads 0. If SNAP and CLR are written together, the snapshot takes the pre-clear value.
    - bit6 PERR: sticky, W1C.
    - bit7 UNLOCKED: read-only status.
  - 0x03 KEY: write-only, reads 0.
  - 0x04 IRQ_STATUS: bit n set on a rising edge of irq_src[n]; written 1s clear bits. A set and a clear on the same cycle leaves the bit set.
  - 0x05 IRQ_EN: RW.
  - 0x08..0x0B CNT_SNAP: snapshot bytes, LSB at 0x08; read-only, writes ignored.
  - 0x10..0x13 PROT: prot_cfg bytes, LSB at 0x10. Write takes effect only when the FSM is UNLOCKED. A write while LOCKED or KEY1 is dropped and sets PERR; if PERR is cleared in the same cycle it is set, set wins.
  - All other addresses read 8'h00; writes to them are ignored.
- Counter:
  - 32-bit, +1 on each clk with cnt_tick = 1; wraps from FFFF_FFFF to 0.
  - CLR takes priority over a simultaneous tick.
- irq output: irq <= |(IRQ_STATUS & IRQ_EN), one cycle of latency after the status/enable change.
- Lock FSM, with states LOCKED, KEY1, UNLOCKED:
  - LOCKED: KEY write of 8'h55 -> KEY1; any other write leaves it in LOCKED.
  - KEY1: KEY write of 8'hAA -> UNLOCKED. Any other csr_we, any address or value, -> LOCKED, and that write is still performed normally except for PROT.
  - UNLOCKED:
    - Any KEY write -> LOCKED.
    - A timeout counter loads UNLOCK_TIMEOUT on entry and decrements each clk; reaching 0 -> LOCKED.
    - A PROT write on the expiry cycle is rejected, sets PERR.
- Writes update registers on the clk edge where csr_we = 1; csr_di reflects the new value from the next cycle.

Decomposition:
- Shared package csr_regs_pkg holds:
  - address constants: ADDR_ID, ADDR_SCRATCH, ADDR_CTRL, ADDR_KEY, ADDR_IRQ_STATUS, ADDR_IRQ_EN, ADDR_CNT0..3, ADDR_PROT0..3
  - KEY1_VAL = 8'h55, KEY2_VAL = 8'hAA
  - CTRL bit indices
  - lock state encoding
- One sub-module is natural: csr_lock, containing the key FSM and timeout counter, with outputs unlocked and reject_pulse.
- The register file, counter and IRQ logic stay in csr_regs.

Test Plan:
- Reset then read every address -> 0x00 reads VERSION, 0x10..0x13 read PROT_RESET bytes, all others read 0x00, irq = 0.
- Write PROT0 = 0x12 while locked -> prot_cfg unchanged, CTRL reads 0x40; write CTRL 0x40 -> CTRL reads 0x00.
- KEY 0x55, KEY 0xAA, PROT0..3 = 78,56,34,12 -> prot_cfg = 32'h1234_5678, CTRL bit7 = 1. After UNLOCK_TIMEOUT (set to 16 in the bench) cycles, a PROT0 write is rejected and CTRL reads 0x40.
- KEY 0x55, SCRATCH 0x3C, KEY 0xAA -> FSM stays LOCKED, SCRATCH reads 0x3C.
- Hold cnt_tick 1 for 300 cycles, write CTRL 0x03 -> CNT_SNAP reads 2C,01,00,00 (exact count per the bench's cycle accounting); the live counter restarts at 0.
- Set IRQ_EN = 0x01, pulse irq_src[0] -> irq = 1 one cycle after the status bit sets. Write IRQ_STATUS 0x01 while irq_src[0] rises again -> status stays 1. A later clear -> irq = 0 the next cycle.
